// File: rtl/morse_blinker.sv
// morse_blinker: serial Morse sender for letters S-Z on one LED; `define MORSE_EXT_TICK_EN to time symbols from the tick port.
// Latency: first led bit one symbol period after load, done one period after the last bit; no backpressure, go ignored while busy.
module morse_blinker #(
  parameter int unsigned TICK_COUNT = 25000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] letter,
  input  logic       go,
  input  logic       tick,
  output logic       led,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [12:0] shreg;
  logic [3:0]  len;
  logic        go_q;
  logic        start;
  logic        sym_tick;
  logic [12:0] pat_sel;
  logic [3:0]  len_sel;

  assign start = go & ~go_q;

  // Patterns left-aligned in 13 bits, dot = 1, dash = 111, gap = 0.
  always_comb begin
    pat_sel = '0;
    len_sel = '0;
    case (letter)
      3'd0: begin pat_sel = 13'b1010100000000; len_sel = 4'd5;  end
      3'd1: begin pat_sel = 13'b1110000000000; len_sel = 4'd3;  end
      3'd2: begin pat_sel = 13'b1010111000000; len_sel = 4'd7;  end
      3'd3: begin pat_sel = 13'b1010101110000; len_sel = 4'd9;  end
      3'd4: begin pat_sel = 13'b1011101110000; len_sel = 4'd9;  end
      3'd5: begin pat_sel = 13'b1110101011100; len_sel = 4'd11; end
      3'd6: begin pat_sel = 13'b1110101110111; len_sel = 4'd13; end
      3'd7: begin pat_sel = 13'b1110111010100; len_sel = 4'd11; end
      default: begin pat_sel = '0; len_sel = '0; end
    endcase
  end

`ifdef MORSE_EXT_TICK_EN
  assign sym_tick = tick;
`else
  localparam int DIV_W = $clog2(TICK_COUNT);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_COUNT - 1);

  logic [DIV_W-1:0] div;
  logic             unused_tick;

  assign unused_tick = tick;
  assign sym_tick    = (div == DIV_MAX);

  // Restarting on load makes the first symbol a full period long.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      div <= '0;
    end else if ((state == IDLE) && start) begin
      div <= '0;
    end else if (sym_tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end
`endif

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
      shreg <= '0;
      len   <= '0;
      go_q  <= 1'b0;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      go_q <= go;
      done <= 1'b0;
      case (state)
        IDLE: begin
          led <= 1'b0;
          if (start) begin
            shreg <= pat_sel;
            len   <= len_sel;
            busy  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (sym_tick) begin
            if (len != 4'd0) begin
              led   <= shreg[12];
              shreg <= {shreg[11:0], 1'b0};
              len   <= len - 4'd1;
            end else begin
              // One dark period after the last bit, then finish.
              led   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_blinker.sv
// Bench for morse_blinker: per-letter expectations queued at stimulus time, compared every cycle against
// an independent symbol-period timeline; works for both internal and external tick builds.
module tb_morse_blinker;

  localparam int TC = 4;
`ifdef MORSE_EXT_TICK_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic [2:0] letter;
  logic       go;
  logic       tick;
  logic       led;
  logic       busy;
  logic       done;

  morse_blinker #(.TICK_COUNT(TC)) dut (
    .clock  (clock),
    .resetn (resetn),
    .letter (letter),
    .go     (go),
    .tick   (tick),
    .led    (led),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  string pats[8] = '{"10101", "111", "1010111", "101010111",
                     "101110111", "11101010111", "1110101110111", "11101110101"};

  string exp_q[$];
  string cur = "";
  bit    active = 1'b0;
  bit    load_pending = 1'b0;
  bit    exp_done = 1'b0;
  logic  exp_led;
  int    n = 0;
  int    k = 0;

  // Expected timeline: n = edges since load, k = symbol ticks since load.
  always @(posedge clock or posedge resetn) begin
    if (resetn) begin
      active       = 1'b0;
      load_pending = 1'b0;
      exp_done     = 1'b0;
      exp_q.delete();
    end else begin
      exp_done = 1'b0;
      if (active) begin
        n++;
        if (EXT ? (tick == 1'b1) : (n % TC == 0)) k++;
        if (k == cur.len() + 1) begin
          exp_done = 1'b1;
          active   = 1'b0;
        end
      end
      if (load_pending && exp_q.size() > 0) begin
        load_pending = 1'b0;
        cur    = exp_q.pop_front();
        active = 1'b1;
        n      = 0;
        k      = 0;
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (!resetn) begin
      exp_led = active && (k >= 1) && (k <= cur.len()) && (cur[k-1] == "1");
      check("led", led, exp_led);
      check("busy", busy, active);
      check("done", done, exp_done);
    end
  end

  // Irregular symbol ticks; ignored by the DUT in the internal-divider build.
  int gaps[3] = '{2, 7, 3};
  initial begin
    tick = 1'b0;
    forever begin
      for (int g = 0; g < 3; g++) begin
        repeat (gaps[g]) begin
          @(negedge clock);
          tick = 1'b0;
        end
        @(negedge clock);
        tick = 1'b1;
      end
    end
  end

  task automatic send_letter(input logic [2:0] l, input bit hold);
    @(negedge clock);
    letter = l;
    go     = 1'b1;
    exp_q.push_back(pats[l]);
    load_pending = 1'b1;
    if (!hold) begin
      @(negedge clock);
      go = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && (active || load_pending); i++) @(negedge clock);
    check("wait_idle", {31'd0, active}, 32'd0);
  endtask

  initial begin
    letter = 3'd0;
    go     = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    resetn = 1'b0;

    send_letter(3'd0, 1'b0);
    wait_idle(60);

    send_letter(3'd6, 1'b0);
    repeat (10) @(negedge clock);
    letter = 3'd0;
    wait_idle(200);

    send_letter(3'd1, 1'b1);
    wait_idle(200);
    repeat (3 * TC) @(negedge clock);
    go = 1'b0;
    @(negedge clock);
    send_letter(3'd2, 1'b0);
    wait_idle(200);

    send_letter(3'd1, 1'b0);
    repeat (2) @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    wait_idle(200);

    send_letter(3'd6, 1'b0);
    for (int i = 0; i < 200 && k < 3; i++) @(negedge clock);
    check("pre_rst_led", led, 1);
    resetn = 1'b1;
    #1;
    check("arst_led", led, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clock);
    resetn = 1'b0;
    send_letter(3'd1, 1'b0);
    wait_idle(200);

    send_letter(3'd7, 1'b0);
    wait_idle(300);
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
